seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Iterative multiply/divide unit for the 16-bit CPU datapath.
- Sits beside the ALU, directly upstream of the writeback result mux.
- The controller pulses start with two register operands and waits for done. The mux then selects lo (and hi, via a second writeback) into the register file flops.
- One result bit is produced per clock, which keeps area small at the cost of multi-cycle latency.

Parameters:
- WIDTH, 16, operand width; product/quotient-remainder is 2*WIDTH bits (hi:lo).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- c  input  1  clock, all state updates on rising edge.
- r  input  1  reset, asynchronous, active-low; clears all state immediately on assertion.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 reserved.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while iterating.
- done  output  1  single-cycle completion pulse.
- lo  output  WIDTH  product low half / quotient.
- hi  output  WIDTH  product high half / remainder.
- err  output  1  divide-by-zero or unsupported op; valid with done, held with results.

Behaviour:
- Reset (r low, async): state=IDLE, busy=0, done=0, lo=0, hi=0, err=0, counter=0, internal operand regs=0.
- States:
  - IDLE: start=1 latches a, b, op; goes to RUN; counter=0.
  - RUN: one iteration per cycle. After WIDTH iterations, goes to DONE.
  - DONE: done=1 for exactly one cycle. Next state is IDLE; it is RUN if start=1 in this cycle.
- Latency: start sampled at edge N. busy=1 during cycles N+1..N+WIDTH. done=1 during cycle N+WIDTH+1. lo/hi/err are valid from that cycle and held until the next accepted start.
- busy and done are never high together.
- start while in RUN is ignored; a, b and op are not re-sampled.
- Accepting a new start clears err on the next edge. lo/hi hold their old values until the new DONE.
- MULU: shift-add over a 2*WIDTH accumulator; the result is the exact unsigned 2*WIDTH product.
- MULS:
  - Operands are two's complement.
  - Magnitudes are taken at latch time and multiplied unsigned.
  - The 2*WIDTH result is negated if the sign bits differ.
  - -2^(WIDTH-1) operands are handled exactly (magnitude fits in WIDTH unsigned bits).
- DIVU:
  - Restoring division, one quotient bit per cycle; lo=quotient, hi=remainder.
  - b=0: same latency; lo=all ones, hi=a, err=1.
- op=11: same latency, lo=0, hi=0, err=1.
- Reset asserted mid-RUN aborts immediately to IDLE with all outputs zero. No done pulse follows.
- Operands a/b may change freely after the start cycle without affecting the result.

Optional Feature:
- Macro: SEQ_MUL_DIV_DIVIDE_EN.
- Defined: DIVU implemented as above.
- Undefined: divider datapath omitted; op=10 behaves as op=11 (lo=0, hi=0, err=1, same WIDTH+1 latency). MULU/MULS are unaffected.

Test Plan:
- MULU, a=0xFFFF, b=0xFFFF, start at edge N -> busy cycles N+1..N+16, done at N+17, hi=0xFFFE, lo=0x0001, err=0.
- MULS, a=0xFFFD (-3), b=0x0007 -> hi=0xFFFF, lo=0xFFEB.
- MULS, a=0x8000, b=0x8000 -> hi=0x4000, lo=0x0000.
- DIVU, a=100, b=7 -> lo=14, hi=2, err=0.
- DIVU, a=5, b=0 -> lo=0xFFFF, hi=0x0005, err=1.
- With SEQ_MUL_DIV_DIVIDE_EN undefined, DIVU 100/7 -> lo=0, hi=0, err=1.
- Pulse start again during busy with different operands -> ignored; the first result is delivered unchanged.
- Assert r low at the 5th busy cycle -> busy, done, lo, hi, err all 0 immediately.
- After releasing r, a new MULU 3*4 -> lo=12 after 17 cycles.
- Back-to-back: start held during the DONE cycle of 2*3 -> lo=6 pulses done, then 16 busy cycles, then done with the new result. Old lo=6 is held while the new op is busy.

Source files
------------

// File: rtl/seq_mul_div.sv
// rtl/seq_mul_div.sv - iterative one-bit-per-cycle multiply/divide unit (divider enabled by SEQ_MUL_DIV_DIVIDE_EN)
module seq_mul_div #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             c,
    input  logic             r,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             err
);

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
    localparam logic [1:0] OP_DIVU = 2'b10;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   dvs;
    logic [2*WIDTH-1:0] p;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] res;
    logic               res_err;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
    logic [WIDTH:0]     div_r;
    logic [WIDTH:0]     div_d;
`endif

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    // Signed magnitudes; -2^(WIDTH-1) maps onto itself, which is exact as unsigned.
    always_comb begin
        mag_a = a[WIDTH-1] ? (~a) + WIDTH'(1) : a;
        mag_b = b[WIDTH-1] ? (~b) + WIDTH'(1) : b;
    end

    // One iteration: p holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, dvs};
        mul_step = p[0] ? {mul_sum, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};
        step     = mul_step;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
        div_r = p[2*WIDTH-1:WIDTH-1];
        div_d = div_r - {1'b0, dvs};
        if (op_q == OP_DIVU) begin
            step = div_d[WIDTH] ? {div_r[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                : {div_d[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Final result formed from the last iteration, captured into lo/hi on the way to DONE.
    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (op_q)
            OP_MULU: res = step;
            OP_MULS: res = neg_q ? -step : step;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
            OP_DIVU: begin
                res = step;
                if (dvs == '0) begin
                    // Remainder naturally ends up equal to the dividend; force quotient to all ones.
                    res[WIDTH-1:0] = '1;
                    res_err        = 1'b1;
                end
            end
`endif
            default: begin
                res     = '0;
                res_err = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge c or negedge r) begin
        if (!r) state <= S_IDLE;
        else    state <= state_nxt;
    end

    // Next-state logic; DONE may chain straight into another RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and held results.
    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            dvs   <= '0;
            p     <= '0;
            lo    <= '0;
            hi    <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= op;
            neg_q <= (op == OP_MULS) && (a[WIDTH-1] ^ b[WIDTH-1]);
            dvs   <= (op == OP_MULS) ? mag_b : b;
            p     <= {{WIDTH{1'b0}}, (op == OP_MULS) ? mag_a : a};
            err   <= 1'b0;
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            p   <= step;
            if (last) begin
                lo  <= res[WIDTH-1:0];
                hi  <= res[2*WIDTH-1:WIDTH];
                err <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// tb/tb_seq_mul_div.sv - scoreboard bench for seq_mul_div
module tb_seq_mul_div;

    localparam int W = 16;

    logic          c = 1'b0;
    logic          r = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic          err;

    seq_mul_div #(.WIDTH(W), .CNT_W(5)) dut (
        .c(c), .r(r), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .lo(lo), .hi(hi), .err(err)
    );

    always #5 c = ~c;

    int cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         err;
        int           at;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: pop and compare whenever the DUT presents done.
    always @(negedge c) begin
        if (r) begin
            if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    check("lo", lo, m_e.lo);
                    check("hi", hi, m_e.hi);
                    check("err", err, m_e.err);
                    check("done_cycle", cyc, m_e.at);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic eerr);
        exp_t e;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge c);
        #1;
        start = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        op = 2'b11;
        e.lo = elo;
        e.hi = ehi;
        e.err = eerr;
        e.at = cyc + W;
        exp_q.push_back(e);
    endtask

    task automatic wait_quiet();
        int waited = 0;
        while (waited < 200) begin
            @(negedge c);
            if (!busy && exp_q.size() == 0) break;
            waited++;
        end
        check("quiet_timeout", 32'(waited >= 200), 32'd0);
    endtask

    task automatic wait_done();
        int waited = 0;
        while (waited < 40) begin
            @(negedge c);
            if (done) break;
            waited++;
        end
        check("done_timeout", 32'(waited >= 40), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge c);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lo", lo, 0);
        check("rst_hi", hi, 0);
        check("rst_err", err, 0);
        r = 1'b1;
        @(negedge c);

        issue(2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge c);
            check("busy_run", busy, 1);
            check("done_run", done, 0);
        end
        @(negedge c);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        @(negedge c);
        check("done_single", done, 0);
        wait_quiet();

        issue(2'b01, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 1'b0);
        wait_quiet();
        issue(2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0);
        wait_quiet();
`ifdef SEQ_MUL_DIV_DIVIDE_EN
        issue(2'b10, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
`else
        issue(2'b10, 16'd100, 16'd7, 16'd0, 16'd0, 1'b1);
`endif
        wait_quiet();
        issue(2'b11, 16'd3, 16'd4, 16'd0, 16'd0, 1'b1);
        wait_quiet();
`ifdef SEQ_MUL_DIV_DIVIDE_EN
        issue(2'b10, 16'd5, 16'd0, 16'hFFFF, 16'h0005, 1'b1);
`else
        issue(2'b10, 16'd5, 16'd0, 16'h0000, 16'h0000, 1'b1);
`endif
        wait_quiet();

        issue(2'b00, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0);
        check("err_cleared", err, 0);
`ifdef SEQ_MUL_DIV_DIVIDE_EN
        check("lo_held", lo, 16'hFFFF);
        check("hi_held", hi, 16'h0005);
`else
        check("lo_held", lo, 16'h0000);
        check("hi_held", hi, 16'h0000);
`endif
        repeat (2) @(posedge c);
        #1;
        start = 1'b1;
        op = 2'b11;
        a = 16'd9;
        b = 16'd9;
        @(posedge c);
        #1;
        start = 1'b0;
        check("busy_ignore_start", busy, 1);
        wait_quiet();

        issue(2'b00, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001, 1'b0);
        repeat (4) @(posedge c);
        #3;
        check("busy_before_abort", busy, 1);
        r = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_lo", lo, 0);
        check("abort_hi", hi, 0);
        check("abort_err", err, 0);
        exp_q.delete();
        @(negedge c);
        r = 1'b1;
        repeat (20) @(negedge c);
        wait_quiet();

        issue(2'b00, 16'd3, 16'd4, 16'd12, 16'd0, 1'b0);
        wait_quiet();

        issue(2'b00, 16'd2, 16'd3, 16'd6, 16'd0, 1'b0);
        wait_done();
        issue(2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        check("b2b_lo_held", lo, 16'd6);
        repeat (8) @(negedge c);
        check("b2b_lo_held_mid", lo, 16'd6);
        wait_quiet();

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
